// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential 16-bit binary to 5-digit packed BCD converter using
// shift-and-add-3 (double dabble), one input bit per clock.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   rst     in   1   asynchronous active-low reset
//   start   in   1   level input; a 0->1 edge requests a conversion
//   bin_in  in  16   unsigned binary value, captured on the accepted start edge
//   bcd     out 20   packed BCD result (bcd[3:0] = ones), held between runs
//   valid   out  1   one-cycle pulse when bcd has just been updated
//   busy    out  1   high from the accepting edge until the cycle after valid
//   blank   out  5   leading-zero blank mask (per digit)
//   state   out  2   FSM state: 0 IDLE, 1 SHIFT, 2 DONE
//
// Optional feature macro: BIN2BCD_BLANK_EN
//   defined     -> blank[i] = 1 when digit i and all higher digits are zero,
//                  blank[0] always 0, registered together with bcd.
//   not defined -> blank is tied to zero.
// -----------------------------------------------------------------------------
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic [19:0] bcd,
  output logic        valid,
  output logic        busy,
  output logic [4:0]  blank,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_start_q;
  logic [3:0]  r_cnt;
  logic [35:0] r_scratch;   // {bcd[19:0], binary[15:0]}
  logic [19:0] r_bcd;
  logic        r_valid;
  logic        r_busy;

  logic        w_start_edge;
  logic [19:0] w_bcd_adj;
  logic [35:0] w_shifted;

  // Add 3 to a BCD nibble that is 5 or more, so the following shift carries
  // correctly into the next decimal digit.
  function automatic logic [3:0] f_add3(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) begin
      r = n + 4'd3;
    end else begin
      r = n;
    end
    return r;
  endfunction

  assign w_start_edge = start & ~r_start_q;

  // Adjust all five digits in parallel, then shift the whole scratch left;
  // the binary MSB falls into the BCD LSB.
  always_comb begin
    w_bcd_adj = 20'h00000;
    for (int i = 0; i < 5; i++) begin
      w_bcd_adj[4*i +: 4] = f_add3(r_scratch[16 + 4*i +: 4]);
    end
    w_shifted = {w_bcd_adj, r_scratch[15:0]} << 6'd1;
  end

  // Start-level history for edge detection; tracks start in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= start;
    end
  end

  // Next-state logic; edges seen outside IDLE are simply dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_state_next = ST_SHIFT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == 4'd15) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Scratch, bit counter and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scratch <= 36'h0_0000_0000;
      r_cnt     <= 4'd0;
      r_bcd     <= 20'h00000;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) begin
            r_scratch <= {20'h00000, bin_in};
            r_cnt     <= 4'd0;
          end
        end
        ST_SHIFT: begin
          r_scratch <= w_shifted;
          r_cnt     <= r_cnt + 4'd1;
        end
        ST_DONE: begin
          r_bcd   <= r_scratch[35:16];
          r_valid <= 1'b1;
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  // busy covers the accepting edge through the cycle in which valid is high,
  // so it stays asserted one cycle past the return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_next != ST_IDLE) || (r_state == ST_DONE);
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [4:0] r_blank;

  // A digit is blanked when it and every more-significant digit are zero;
  // the ones digit is never blanked so zero still displays as "0".
  function automatic logic [4:0] f_blank(input logic [19:0] d);
    logic [4:0] m;
    m[4] = (d[19:16] == 4'd0);
    m[3] = m[4] && (d[15:12] == 4'd0);
    m[2] = m[3] && (d[11:8]  == 4'd0);
    m[1] = m[2] && (d[7:4]   == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

  // Blank mask is registered alongside bcd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blank <= 5'b00000;
    end else if (r_state == ST_DONE) begin
      r_blank <= f_blank(r_scratch[35:16]);
    end else begin
      r_blank <= r_blank;
    end
  end

  assign blank = r_blank;
`else
  assign blank = 5'b00000;
`endif

  assign bcd   = r_bcd;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign state = r_state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq. Expected values come from a decimal
// arithmetic model (divide/modulo by 10, comparison against powers of 10).
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic [19:0] bcd;
  logic        valid;
  logic        busy;
  logic [4:0]  blank;
  logic [1:0]  state;

  int n_checks;
  int n_errors;

  bin2bcd_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (bin_in),
    .bcd    (bcd),
    .valid  (valid),
    .busy   (busy),
    .blank  (blank),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division.
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int t;
    t = v;
    r = 20'h00000;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: digit i and above are all zero exactly when v < 10**i.
  function automatic logic [4:0] ref_blank(input int v);
    logic [4:0] m;
    int p;
    m = 5'b00000;
`ifdef BIN2BCD_BLANK_EN
    p = 10;
    for (int i = 1; i < 5; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
`else
    p = v;
`endif
    return m;
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bcd"},   bcd,           20'h00000);
    chk({tag, "_valid"}, 20'(valid),    20'd0);
    chk({tag, "_busy"},  20'(busy),     20'd0);
    chk({tag, "_blank"}, 20'(blank),    20'd0);
    chk({tag, "_state"}, 20'(state),    20'd0);
  endtask

  // One conversion. second_at > 0 raises start again (with a different
  // bin_in) so that the edge is sampled at E+second_at, and holds it high.
  task automatic convert(input logic [15:0] v, input int second_at);
    logic [19:0] eb;
    logic [4:0]  ebl;
    int lat;
    int pulses;
    logic [1:0] est;
    eb  = ref_bcd(int'(v));
    ebl = ref_blank(int'(v));
    bin_in = v;
    start  = 1'b1;
    tick();                       // edge E
    chk("busy_E",  20'(busy),  20'd1);
    chk("state_E", 20'(state), 20'd1);
    start  = 1'b0;
    bin_in = ~v;                  // must not affect the result
    lat = 0;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      if (second_at != 0 && c == second_at) begin
        start  = 1'b1;
        bin_in = v ^ 16'h5a5a;
      end
      tick();                     // edge E+c
      if (valid) begin
        pulses++;
        if (lat == 0) lat = c;
      end
      chk("busy", 20'(busy), 20'(c <= 17));
      if (c < 16)       est = 2'd1;
      else if (c == 16) est = 2'd2;
      else              est = 2'd0;
      chk("state", 20'(state), 20'(est));
      if (c == 17) begin
        chk("bcd_at_valid", bcd, eb);
      end
    end
    chk("latency",  20'(lat),    20'd17);
    chk("pulses",   20'(pulses), 20'd1);
    chk("bcd_held", bcd,         eb);
    chk("blank",    20'(blank),  20'(ebl));
    start = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst    = 1'b0;
    start  = 1'b0;
    bin_in = 16'd0;
    repeat (3) tick();
    chk_reset_outputs("in_reset");
    rst = 1'b1;

    // Idle after reset with start low: nothing changes for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_bcd",   bcd,            20'h00000);
      chk("idle_valid", 20'(valid),     20'd0);
      chk("idle_busy",  20'(busy),      20'd0);
      chk("idle_state", 20'(state),     20'd0);
    end

    // Directed values.
    convert(16'd12345, 0);
    convert(16'd225,   0);
    convert(16'd65535, 0);
    convert(16'd0,     0);
    convert(16'd9,     0);
    convert(16'd10000, 0);

    // Second edge at E+5 is ignored; start then stays high with no rerun.
    convert(16'd4096, 5);

    // Randomized values.
    for (int k = 0; k < 20; k++) begin
      convert(16'($urandom_range(0, 65535)), 0);
    end

    // Reset mid-conversion aborts and clears everything at once.
    bin_in = 16'd4321;
    start  = 1'b1;
    tick();                       // edge E
    start  = 1'b0;
    repeat (8) tick();            // E+8
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");

    // start held high through reset release is taken as an edge.
    bin_in = 16'd999;
    start  = 1'b1;
    tick();
    chk_reset_outputs("held_reset");
    rst = 1'b1;
    convert(16'd999, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
